// File: rtl/mips_pipeline_pkg.sv
// Shared MIPS pipeline definitions: zero-register address, write-back source
// encoding and the write-back control bundle carried from MEM into WB.
package mips_pipeline_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_MEM  = 2'd1,
        WB_SRC_LINK = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic Valid;
        logic RegWrite;
        logic MemtoReg;
        logic JalLink;
    } wb_ctrl_t;

    // JalLink outranks MemtoReg: a jal must always link PC+4.
    function automatic wb_src_e wbSrcOf(input wb_ctrl_t ctrl);
        if (ctrl.JalLink)       return WB_SRC_LINK;
        else if (ctrl.MemtoReg) return WB_SRC_MEM;
        else                    return WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: hazard controls and MEM-side entry in, register-file write port out.
interface mem_wb_if #(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
);
    logic                   Stall;
    logic                   Flush;
    logic                   MEM_Valid;
    logic                   MEM_RegWrite;
    logic                   MEM_MemtoReg;
    logic                   MEM_JalLink;
    logic [RegAddrBits-1:0] MEM_WriteReg;
    logic [NBits-1:0]       MemoryData;
    logic [NBits-1:0]       ALUResult;
    logic [NBits-1:0]       PC_4;
    logic                   WB_Valid;
    logic                   WB_RegWrite;
    logic [RegAddrBits-1:0] WB_WriteReg;
    logic [NBits-1:0]       WB_WriteData;

    modport master (
        output Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_JalLink,
               MEM_WriteReg, MemoryData, ALUResult, PC_4,
        input  WB_Valid, WB_RegWrite, WB_WriteReg, WB_WriteData
    );

    modport slave (
        input  Stall, Flush, MEM_Valid, MEM_RegWrite, MEM_MemtoReg, MEM_JalLink,
               MEM_WriteReg, MemoryData, ALUResult, PC_4,
        output WB_Valid, WB_RegWrite, WB_WriteReg, WB_WriteData
    );
endinterface

// File: rtl/mem_wb_stage_wb_source_select.sv
// Write-back data mux: ALU / load data / PC+4, built as a chain of two 2:1 muxes
// so the link source sits closest to the output.
module Multiplexer2to1 #(
    parameter int NBits = 32
) (
    input  logic [NBits-1:0] muxIn0,
    input  logic [NBits-1:0] muxIn1,
    input  logic             selector,
    output logic [NBits-1:0] muxOut
);
    assign muxOut = selector ? muxIn1 : muxIn0;
endmodule

module wb_source_select
    import mips_pipeline_pkg::*;
#(
    parameter int NBits = 32
) (
    input  wb_src_e          srcSel,
    input  logic [NBits-1:0] aluResult,
    input  logic [NBits-1:0] memoryData,
    input  logic [NBits-1:0] pc4,
    output logic [NBits-1:0] writeData
);
    logic [NBits-1:0] aluOrMem;

    Multiplexer2to1 #(.NBits(NBits)) uMuxMem (
        .muxIn0  (aluResult),
        .muxIn1  (memoryData),
        .selector(srcSel == WB_SRC_MEM),
        .muxOut  (aluOrMem)
    );

    Multiplexer2to1 #(.NBits(NBits)) uMuxLink (
        .muxIn0  (aluOrMem),
        .muxIn1  (pc4),
        .selector(srcSel == WB_SRC_LINK),
        .muxOut  (writeData)
    );
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and stall/flush handling.
// Define MEM_WB_RETIRE_COUNT_EN to add the 32-bit RetireCount register and port.
module mem_wb_stage
    import mips_pipeline_pkg::*;
#(
    parameter int NBits       = 32,
    parameter int RegAddrBits = 5
) (
    input  logic        clk,
    input  logic        reset,
    mem_wb_if.slave     bus
`ifdef MEM_WB_RETIRE_COUNT_EN
    ,
    output logic [31:0] RetireCount
`endif
);
    wb_ctrl_t               ctrlQ;
    logic [RegAddrBits-1:0] writeRegQ;
    logic [NBits-1:0]       memDataQ;
    logic [NBits-1:0]       aluResultQ;
    logic [NBits-1:0]       pc4Q;

    always_ff @(posedge clk) begin
        if (!reset || bus.Flush) begin
            ctrlQ      <= '0;
            writeRegQ  <= '0;
            memDataQ   <= '0;
            aluResultQ <= '0;
            pc4Q       <= '0;
        end else if (!bus.Stall) begin
            ctrlQ.Valid    <= bus.MEM_Valid;
            ctrlQ.RegWrite <= bus.MEM_RegWrite;
            ctrlQ.MemtoReg <= bus.MEM_MemtoReg;
            ctrlQ.JalLink  <= bus.MEM_JalLink;
            writeRegQ      <= bus.MEM_WriteReg;
            memDataQ       <= bus.MemoryData;
            aluResultQ     <= bus.ALUResult;
            pc4Q           <= bus.PC_4;
        end
    end

    wb_source_select #(.NBits(NBits)) uSrcSel (
        .srcSel    (wbSrcOf(ctrlQ)),
        .aluResult (aluResultQ),
        .memoryData(memDataQ),
        .pc4       (pc4Q),
        .writeData (bus.WB_WriteData)
    );

    assign bus.WB_Valid    = ctrlQ.Valid;
    assign bus.WB_WriteReg = writeRegQ;
    // Bubbles and $zero targets never reach the register file.
    assign bus.WB_RegWrite = ctrlQ.Valid & ctrlQ.RegWrite
                           & (writeRegQ != RegAddrBits'(REG_ZERO));

`ifdef MEM_WB_RETIRE_COUNT_EN
    // An entry retires when it leaves WB: advanced normally or flushed out.
    always_ff @(posedge clk) begin
        if (!reset)
            RetireCount <= '0;
        else if (ctrlQ.Valid && (!bus.Stall || bus.Flush))
            RetireCount <= RetireCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a behavioural entry model.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_wb_if #(.NBits(32), .RegAddrBits(5)) bus ();

`ifdef MEM_WB_RETIRE_COUNT_EN
    logic [31:0] RetireCount;
    mem_wb_stage #(.NBits(32), .RegAddrBits(5)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .RetireCount(RetireCount));
`else
    mem_wb_stage #(.NBits(32), .RegAddrBits(5)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
`endif

    // Model of the single WB entry as seen at the write port.
    logic        mValid, mRegWrite;
    logic [4:0]  mWriteReg;
    logic [31:0] mWriteData;
    logic [31:0] mCount;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setIn(input logic v, rw, m2r, jal, input logic [4:0] wr,
                         input logic [31:0] md, alu, pc);
        bus.MEM_Valid = v; bus.MEM_RegWrite = rw; bus.MEM_MemtoReg = m2r;
        bus.MEM_JalLink = jal; bus.MEM_WriteReg = wr;
        bus.MemoryData = md; bus.ALUResult = alu; bus.PC_4 = pc;
    endtask

    task automatic randIn();
        setIn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3) == 0,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom, $urandom);
    endtask

    // Advance one clock; the model applies the same edge rules from the spec text.
    task automatic tick();
        logic        nV, nRW;
        logic [4:0]  nWR;
        logic [31:0] nWD, nCnt;
        nV = mValid; nRW = mRegWrite; nWR = mWriteReg; nWD = mWriteData; nCnt = mCount;
        if (!reset) begin
            nV = 0; nRW = 0; nWR = 0; nWD = 0; nCnt = 0;
        end else begin
            if (mValid && (!bus.Stall || bus.Flush)) nCnt = mCount + 1;
            if (bus.Flush) begin
                nV = 0; nRW = 0; nWR = 0; nWD = 0;
            end else if (!bus.Stall) begin
                nV  = bus.MEM_Valid;
                nRW = bus.MEM_RegWrite;
                nWR = bus.MEM_WriteReg;
                nWD = bus.MEM_JalLink  ? bus.PC_4 :
                      bus.MEM_MemtoReg ? bus.MemoryData : bus.ALUResult;
            end
        end
        @(posedge clk);
        #1;
        mValid = nV; mRegWrite = nRW; mWriteReg = nWR; mWriteData = nWD; mCount = nCnt;
    endtask

    task automatic checkModel(input string tag);
        chk({tag, ".valid"}, 32'(bus.WB_Valid), 32'(mValid));
        chk({tag, ".we"},    32'(bus.WB_RegWrite),
            32'(mValid && mRegWrite && mWriteReg != 0));
        chk({tag, ".wreg"},  32'(bus.WB_WriteReg), 32'(mWriteReg));
        chk({tag, ".wdata"}, bus.WB_WriteData, mWriteData);
`ifdef MEM_WB_RETIRE_COUNT_EN
        chk({tag, ".retire"}, RetireCount, mCount);
`endif
    endtask

    initial begin
        mValid = 0; mRegWrite = 0; mWriteReg = 0; mWriteData = 0; mCount = 0;
        // Reset with every input held high.
        reset = 0; bus.Stall = 1; bus.Flush = 1;
        setIn(1, 1, 1, 1, 5'h1F, '1, '1, '1);
        tick(); tick();
        chk("rst.valid", 32'(bus.WB_Valid), 0);
        chk("rst.we",    32'(bus.WB_RegWrite), 0);
        chk("rst.wreg",  32'(bus.WB_WriteReg), 0);
        chk("rst.wdata", bus.WB_WriteData, 0);
`ifdef MEM_WB_RETIRE_COUNT_EN
        chk("rst.retire", RetireCount, 0);
`endif

        reset = 1; bus.Stall = 0; bus.Flush = 0;
        setIn(1, 1, 1, 0, 5'd8, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222);
        tick();
        chk("load.we",    32'(bus.WB_RegWrite), 1);
        chk("load.wreg",  32'(bus.WB_WriteReg), 8);
        chk("load.wdata", bus.WB_WriteData, 32'hDEAD_BEEF);

        setIn(1, 1, 0, 0, 5'd0, 32'h3333_3333, 32'd5, 32'h4444_4444);
        tick();
        chk("zero.valid", 32'(bus.WB_Valid), 1);
        chk("zero.we",    32'(bus.WB_RegWrite), 0);
        chk("zero.wdata", bus.WB_WriteData, 32'd5);

        setIn(1, 1, 1, 1, 5'd31, 32'h5555_5555, 32'h6666_6666, 32'h0040_0024);
        tick();
        chk("jal.wreg",  32'(bus.WB_WriteReg), 31);
        chk("jal.wdata", bus.WB_WriteData, 32'h0040_0024);

        bus.Stall = 1;
        for (int i = 0; i < 3; i++) begin
            randIn();
            tick();
            chk("stall.we",    32'(bus.WB_RegWrite), 1);
            chk("stall.wreg",  32'(bus.WB_WriteReg), 31);
            chk("stall.wdata", bus.WB_WriteData, 32'h0040_0024);
        end
        bus.Flush = 1;
        randIn();
        tick();
        chk("flush.valid", 32'(bus.WB_Valid), 0);
        chk("flush.we",    32'(bus.WB_RegWrite), 0);
        chk("flush.wdata", bus.WB_WriteData, 0);

`ifdef MEM_WB_RETIRE_COUNT_EN
        // Five valid entries separated by stall cycles retire exactly five.
        reset = 0; bus.Stall = 0; bus.Flush = 0; tick(); reset = 1;
        for (int i = 0; i < 5; i++) begin
            bus.Stall = 0; setIn(1, 1, 0, 0, 5'd3, 0, i, 0); tick();
            bus.Stall = 1; tick();
        end
        bus.Stall = 0; setIn(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("retire5", RetireCount, 32'd5);
`endif

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) != 0);
            bus.Stall = ($urandom_range(0, 3) == 0);
            bus.Flush = ($urandom_range(0, 9) == 0);
            randIn();
            tick();
            checkModel("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
